branch_predict_ctrl: RTL and testbench
======================================

// Module: branch_predict_ctrl
// PURPOSE
//  Next-generation branch/jump control for the 5-stage pipeline. Replaces static
//  predict-taken with a PC-indexed table of saturating counters (BHT).
//  - IF stage: looks up the BHT for each BEQ/BNE.
//  - ID stage: resolves the branch, trains the counter, and drives PC-select and
//    IF/ID flush on a mispredict or a jump.
//  - Keeps branch and mispredict statistics counters.
// PARAMETERS
//  IDX_W     6      BHT index width; 2**IDX_W entries, index = pc[IDX_W+1:2]
//  CNT_W     2      counter width per entry; prediction = counter MSB
//  INIT_CNT  1      counter value after reset (weakly not-taken)
//  STAT_W    32     width of statistics counters
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous active-high reset
//  OP_if         in   6      opcode of the instruction in IF
//  pc_if         in   32     PC of the instruction in IF
//  OP_id         in   6      opcode of the instruction in ID
//  pc_id         in   32     PC of the instruction in ID
//  branch_equal  in   1      rs==rt comparison, valid in ID
//  Jump          in   2      jump type from the decoder; 01/10 = jump
//  id_stall      in   1      ID is held this cycle (hazard); IF/ID is not written
//  Branch        out  2      PC select: 00 pc+4, 01 predicted target (IF),
//                            10 recover pc_id+4, 11 recover branch target (ID)
//  IF_flush      out  1      clear the IF/ID register
//  pred_if       out  1      prediction for the IF instruction (debug)
//  br_count      out  STAT_W number of branches resolved in ID
//  mp_count      out  STAT_W number of mispredicts
// BEHAVIOUR
//  - br_if = OP_if is BEQ or BNE; br_id likewise for OP_id.
//  - pred_if = br_if & bht[idx(pc_if)][CNT_W-1]. Combinational read, no bypass:
//    a same-cycle write to the same index is seen the following cycle.
//  - pred_id register, captures the prediction travelling with the instruction:
//      rst                  -> 0
//      IF_flush             -> 0
//      !id_stall            -> pred_if
//      id_stall             -> holds
//  - taken_id = (BEQ & branch_equal) | (BNE & !branch_equal).
//  - resolve = br_id & !id_stall.
//  - mispredict = resolve & (taken_id != pred_id).
//  - Branch/IF_flush, evaluated in priority order:
//      1. mispredict: Branch = taken_id ? 11 : 10; IF_flush = 1
//      2. Jump 01/10: Branch = 00; IF_flush = 1 (jump target muxed elsewhere)
//      3. pred_if:    Branch = 01; IF_flush = 0
//      4. otherwise:  Branch = 00; IF_flush = 0
//    Outputs are combinational; latency 0 from the ID inputs.
//  - Training: on resolve, bht[idx(pc_id)] increments if taken_id, else
//    decrements. Saturates at 2**CNT_W-1 and at 0 (never wraps).
//    Exactly one update per branch: no update while id_stall.
//  - Statistics:
//      br_count += resolve
//      mp_count += mispredict
//    Both wrap modulo 2**STAT_W.
//  - rst (synchronous):
//      every BHT entry       -> INIT_CNT
//      pred_id               -> 0
//      br_count, mp_count    -> 0
//    Branch and IF_flush follow from the reset state (00/0 unless the inputs
//    select otherwise). Reset mid-stream discards all training.
//  - Aliasing between PCs sharing an index is accepted; entries carry no tag.
// STRUCTURE
//  - Add to instr_def.v: `BR_SEQ 2'b00, `BR_PRED 2'b01, `BR_RCV_NT 2'b10,
//    `BR_RCV_T 2'b11. OP_BEQ/OP_BNE already live there.
//  - Sub-module bht_table: parametrised array of saturating counters with one
//    combinational read port, one synchronous update port (inc/dec/en), and a
//    synchronous reset to INIT_CNT.
//  - Top level: prediction register, resolve/priority logic, statistics counters.
// TESTING
//  1. Reset, then BEQ in IF at pc 0x40 -> pred_if=0, Branch=00. Same BEQ in ID
//     taken -> Branch=11, IF_flush=1, mp_count=1, entry 0x10 becomes 2.
//  2. Repeat the same branch taken 3 times -> third IF lookup gives pred_if=1,
//     Branch=01; resolving taken gives no flush; counter holds at 3.
//  3. Entry at 3, branch not taken -> Branch=10, IF_flush=1, counter becomes 2;
//     next lookup still predicts taken.
//  4. id_stall=1 for 3 cycles with a BNE in ID -> no flush and no training;
//     br_count is incremented once, only after the stall releases.
//  5. Mispredict in ID with Jump=01 and a BEQ in IF in the same cycle ->
//     Branch=1x, IF_flush=1; the next cycle pred_id=0.
//  6. Assert rst while the table is trained -> every entry reads 1, both
//     counters are 0 on the next cycle.

Source files
------------

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared opcodes, PC-select encodings and decode helpers
// for the branch predictor.
package branch_predict_ctrl_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        BR_SEQ    = 2'b00,
        BR_PRED   = 2'b01,
        BR_RCV_NT = 2'b10,
        BR_RCV_T  = 2'b11
    } br_sel_e;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-facing signal bundle of the branch controller:
// master is the pipeline, slave is the controller.
interface branch_predict_ctrl_if #(
    parameter int STAT_W = 32
);
    logic [5:0]        OP_if;
    logic [31:0]       pc_if;
    logic [5:0]        OP_id;
    logic [31:0]       pc_id;
    logic              branch_equal;
    logic [1:0]        Jump;
    logic              id_stall;
    logic [1:0]        Branch;
    logic              IF_flush;
    logic              pred_if;
    logic [STAT_W-1:0] br_count;
    logic [STAT_W-1:0] mp_count;

    modport master (
        output OP_if, pc_if, OP_id, pc_id,
        output branch_equal, Jump, id_stall,
        input  Branch, IF_flush, pred_if,
        input  br_count, mp_count
    );

    modport slave (
        input  OP_if, pc_if, OP_id, pc_id,
        input  branch_equal, Jump, id_stall,
        output Branch, IF_flush, pred_if,
        output br_count, mp_count
    );
endinterface

// File: rtl/branch_predict_ctrl_bht_table.sv
// Untagged table of saturating counters: one combinational
// read port, one synchronous inc/dec update port.
module bht_table #(
    parameter int IDX_W    = 6,
    parameter int CNT_W    = 2,
    parameter int INIT_CNT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             en,
    input  logic             inc,
    input  logic             dec
);
    localparam int N = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt [N];

    assign rd_cnt = cnt[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= CNT_W'(INIT_CNT);
            end
        end else if (en) begin
            if (inc && cnt[wr_idx] != CMAX) begin
                cnt[wr_idx] <= cnt[wr_idx] + 1'b1;
            end else if (dec && cnt[wr_idx] != '0) begin
                cnt[wr_idx] <= cnt[wr_idx] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch control: BHT lookup in IF, resolve/train
// and PC-select/flush in ID, plus branch statistics.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_W    = 6,
    parameter int CNT_W    = 2,
    parameter int INIT_CNT = 1,
    parameter int STAT_W   = 32
) (
    input logic clk,
    input logic rst,
    branch_predict_ctrl_if.slave bus
);
    logic [CNT_W-1:0]  rd_cnt;
    logic              br_if;
    logic              br_id;
    logic              pred;
    logic              pred_id;
    logic              taken_id;
    logic              resolve;
    logic              mispredict;
    logic              jump;
    logic              flush;
    br_sel_e           sel;
    logic [STAT_W-1:0] br_cnt;
    logic [STAT_W-1:0] mp_cnt;
    logic              unused;

    bht_table #(
        .IDX_W    (IDX_W),
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_bht (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (bus.pc_if[IDX_W+1:2]),
        .rd_cnt (rd_cnt),
        .wr_idx (bus.pc_id[IDX_W+1:2]),
        .en     (resolve),
        .inc    (taken_id),
        .dec    (!taken_id)
    );

    assign br_if = is_branch(bus.OP_if);
    assign br_id = is_branch(bus.OP_id);
    assign pred  = br_if & rd_cnt[CNT_W-1];
    assign jump  = (bus.Jump == 2'b01) || (bus.Jump == 2'b10);

    assign taken_id = ((bus.OP_id == OP_BEQ) & bus.branch_equal)
                    | ((bus.OP_id == OP_BNE) & !bus.branch_equal);
    assign resolve    = br_id & !bus.id_stall;
    assign mispredict = resolve & (taken_id != pred_id);

    always_comb begin
        sel   = BR_SEQ;
        flush = 1'b0;
        if (mispredict) begin
            sel   = taken_id ? BR_RCV_T : BR_RCV_NT;
            flush = 1'b1;
        end else if (jump) begin
            flush = 1'b1;
        end else if (pred) begin
            sel = BR_PRED;
        end
    end

    // The prediction follows its instruction into ID; a flush kills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_id <= 1'b0;
        end else if (flush) begin
            pred_id <= 1'b0;
        end else if (!bus.id_stall) begin
            pred_id <= pred;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            br_cnt <= br_cnt + STAT_W'(resolve);
            mp_cnt <= mp_cnt + STAT_W'(mispredict);
        end
    end

    assign bus.Branch   = sel;
    assign bus.IF_flush = flush;
    assign bus.pred_if  = pred;
    assign bus.br_count = br_cnt;
    assign bus.mp_count = mp_cnt;

    assign unused = ^{bus.pc_if[31:IDX_W+2], bus.pc_if[1:0],
                      bus.pc_id[31:IDX_W+2], bus.pc_id[1:0],
                      rd_cnt};

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed-vector scoreboard bench for branch_predict_ctrl.
// Stimulus pushes expectations; a negedge monitor pops them.
module tb_branch_predict_ctrl;
    import branch_predict_ctrl_pkg::*;

    localparam logic [5:0] NOP = 6'h00;

    typedef struct {
        string       name;
        logic [1:0]  br;
        logic        fl;
        logic        pr;
        int unsigned bc;
        int unsigned mc;
        int          eidx;
        int          eval;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    branch_predict_ctrl_if #(.STAT_W(32)) bus ();

    branch_predict_ctrl #(
        .IDX_W    (6),
        .CNT_W    (2),
        .INIT_CNT (1),
        .STAT_W   (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f,
                       input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s.%s: got %0d expected %0d",
                      nm, f, act, exp);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "Branch", bus.Branch, e.br);
            chk(e.name, "IF_flush", bus.IF_flush, e.fl);
            chk(e.name, "pred_if", bus.pred_if, e.pr);
            chk(e.name, "br_count", bus.br_count, e.bc);
            chk(e.name, "mp_count", bus.mp_count, e.mc);
            if (e.eidx >= 0)
                chk(e.name, "bht", dut.u_bht.cnt[e.eidx], e.eval);
        end
    end

    task automatic step(
        input string nm, input logic r,
        input logic [5:0] opi, input logic [31:0] pci,
        input logic [5:0] opd, input logic [31:0] pcd,
        input logic be, input logic [1:0] j, input logic st,
        input logic [1:0] eb, input logic ef, input logic ep,
        input int unsigned ebc, input int unsigned emc,
        input int eidx, input int eval);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.OP_if        = opi;
        bus.pc_if        = pci;
        bus.OP_id        = opd;
        bus.pc_id        = pcd;
        bus.branch_equal = be;
        bus.Jump         = j;
        bus.id_stall     = st;
        e = '{nm, eb, ef, ep, ebc, emc, eidx, eval};
        q.push_back(e);
    endtask

    initial begin
        rst              = 1'b1;
        bus.OP_if        = NOP;
        bus.pc_if        = '0;
        bus.OP_id        = NOP;
        bus.pc_id        = '0;
        bus.branch_equal = 1'b0;
        bus.Jump         = 2'b00;
        bus.id_stall     = 1'b0;
        repeat (2) @(posedge clk);

        // name   rst OPif pcif  OPid pcid be J st  Br fl pr bc mc idx val
        step("rst0", 0, NOP, 0, NOP, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 16, 1);
        step("t1a", 0, OP_BEQ, 32'h40, NOP, 0, 0, 0, 0,
             2'b00, 0, 0, 0, 0, 16, 1);
        step("t1b", 0, NOP, 0, OP_BEQ, 32'h40, 1, 0, 0,
             2'b11, 1, 0, 0, 0, -1, 0);
        step("t1c", 0, NOP, 0, NOP, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 16, 2);
        step("t2a", 0, OP_BEQ, 32'h40, NOP, 0, 0, 0, 0,
             2'b01, 0, 1, 1, 1, -1, 0);
        step("t2b", 0, NOP, 0, OP_BEQ, 32'h40, 1, 0, 0,
             2'b00, 0, 0, 1, 1, -1, 0);
        step("t2c", 0, OP_BEQ, 32'h40, NOP, 0, 0, 0, 0,
             2'b01, 0, 1, 2, 1, 16, 3);
        step("t2d", 0, NOP, 0, OP_BEQ, 32'h40, 1, 0, 0,
             2'b00, 0, 0, 2, 1, -1, 0);
        step("t3a", 0, OP_BEQ, 32'h40, NOP, 0, 0, 0, 0,
             2'b01, 0, 1, 3, 1, 16, 3);
        step("t3b", 0, NOP, 0, OP_BEQ, 32'h40, 0, 0, 0,
             2'b10, 1, 0, 3, 1, -1, 0);
        step("t3c", 0, OP_BEQ, 32'h40, NOP, 0, 0, 0, 0,
             2'b01, 0, 1, 4, 2, 16, 2);
        step("t3d", 0, OP_BNE, 32'h80, OP_BEQ, 32'h40, 1, 0, 0,
             2'b00, 0, 0, 4, 2, -1, 0);
        step("t4a", 0, NOP, 0, OP_BNE, 32'h80, 0, 0, 1,
             2'b00, 0, 0, 5, 2, 16, 3);
        step("t4b", 0, NOP, 0, OP_BNE, 32'h80, 0, 0, 1,
             2'b00, 0, 0, 5, 2, 32, 1);
        step("t4c", 0, NOP, 0, OP_BNE, 32'h80, 0, 0, 1,
             2'b00, 0, 0, 5, 2, 32, 1);
        step("t4d", 0, NOP, 0, OP_BNE, 32'h80, 0, 0, 0,
             2'b11, 1, 0, 5, 2, 32, 1);
        step("t4e", 0, NOP, 0, NOP, 0, 0, 0, 0, 2'b00, 0, 0, 6, 3, 32, 2);
        step("t5a", 0, OP_BNE, 32'h80, NOP, 0, 0, 0, 0,
             2'b01, 0, 1, 6, 3, -1, 0);
        step("t5b", 0, OP_BEQ, 32'h40, OP_BNE, 32'h80, 1, 2'b01, 0,
             2'b10, 1, 1, 6, 3, -1, 0);
        step("t5c", 0, NOP, 0, OP_BEQ, 32'h40, 0, 0, 0,
             2'b00, 0, 0, 7, 4, 32, 1);
        step("t5d", 0, OP_BEQ, 32'h40, NOP, 0, 0, 2'b10, 0,
             2'b00, 1, 1, 8, 4, 16, 2);
        step("t5e", 0, NOP, 0, OP_BEQ, 32'h40, 1, 0, 0,
             2'b11, 1, 0, 8, 4, -1, 0);
        step("t6a", 1, NOP, 0, NOP, 0, 0, 0, 0, 2'b00, 0, 0, 9, 5, 16, 3);
        step("t6b", 0, NOP, 0, NOP, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 16, 1);
        step("t6c", 0, OP_BEQ, 32'h40, NOP, 0, 0, 0, 0,
             2'b00, 0, 0, 0, 0, 32, 1);
        step("t7a", 0, NOP, 0, OP_BEQ, 32'hC0, 0, 0, 0,
             2'b00, 0, 0, 0, 0, 48, 1);
        step("t7b", 0, NOP, 0, OP_BEQ, 32'hC0, 0, 0, 0,
             2'b00, 0, 0, 1, 0, 48, 0);
        step("t7c", 0, OP_BEQ, 32'hC0, NOP, 0, 0, 0, 0,
             2'b00, 0, 0, 2, 0, 48, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, wanted 0",
                     q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
